// File: rtl/testing3_pfb_snap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : testing3_pfb_snap_ctrl_if
// Brief   : PFB sample stream in, snapshot BRAM port A out.
// Revision: 1.0 - initial release
// ============================================================================
interface testing3_pfb_snap_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  bram_we;
  logic                  bram_en_a;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wr_data;

  // master: the capture controller; slave: the stream source / BRAM side
  modport master (
    input  din, din_valid,
    output bram_we, bram_en_a, bram_addr, bram_wr_data
  );
  modport slave (
    output din, din_valid,
    input  bram_we, bram_en_a, bram_addr, bram_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/testing3_pfb_snap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : testing3_pfb_snap_ctrl
// Brief   : Arms on a software edge, optionally waits for trig, then writes a
//           contiguous block of valid PFB words into BRAM port A from addr 0.
// Revision: 1.0 - initial release
// ============================================================================
module testing3_pfb_snap_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  ctrl_arm,
  input  wire logic                  ctrl_trig_en,
  input  wire logic                  ctrl_stop,
  input  wire logic                  trig,
  testing3_pfb_snap_ctrl_if.master   bus,
  output logic                       status_busy,
  output logic                       status_done,
  output logic [ADDR_WIDTH:0]        status_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  arm_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  arm_rise;
  logic                  start;

  always_comb begin
    arm_rise = ctrl_arm & ~arm_q;
    start    = bus.din_valid & (trig | ~ctrl_trig_en);
    state_d  = state_q;
    count_d  = count_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_rise) begin
          state_d = S_ARMED;
          count_d = '0;
        end
      end
      S_ARMED: begin
        // an early stop wins over a start arriving on the same cycle
        if (ctrl_stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = bus.din;
          count_d = ONE;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.din_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_WIDTH-1:0];
          data_d  = bus.din;
          count_d = count_q + ONE;
        end
        if (ctrl_stop || (bus.din_valid && (count_q == LAST_ADDR))) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      // a level already high during reset must not look like an edge
      arm_q   <= ctrl_arm;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= ctrl_arm;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.bram_we      = we_q;
  assign bus.bram_en_a    = we_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_wr_data = data_q;
  assign status_busy      = busy_q;
  assign status_done      = done_q;
  assign status_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_testing3_pfb_snap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_testing3_pfb_snap_ctrl
// Brief   : Randomized bench; expected BRAM writes derived from a sample log.
// Revision: 1.0 - initial release
// ============================================================================
module tb_testing3_pfb_snap_ctrl;
  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_arm = 1'b0, ctrl_trig_en = 1'b0, ctrl_stop = 1'b0, trig = 1'b0;
  logic status_busy, status_done;
  logic [AW:0] status_count;

  testing3_pfb_snap_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  testing3_pfb_snap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_arm     (ctrl_arm),
    .ctrl_trig_en (ctrl_trig_en),
    .ctrl_stop    (ctrl_stop),
    .trig         (trig),
    .bus          (bus),
    .status_busy  (status_busy),
    .status_done  (status_done),
    .status_count (status_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          arm, ten, trig, stop, valid;
    logic [DW-1:0] din;
    int            cyc;
  } smp_t;
  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  smp_t log_q[$];
  wr_t  obs_q[$];
  wr_t  exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic arm_prev = 1'b0;
  bit   last_busy = 0, last_done = 0, m_busy = 0, m_done = 0;
  int   last_cnt = 0, m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write monitor, mid-cycle
  always @(negedge clk) begin
    if (bus.bram_we || bus.bram_en_a) begin
      check("en_eq_we", {63'd0, bus.bram_en_a}, {63'd0, bus.bram_we});
      if (bus.bram_we) obs_q.push_back('{int'(bus.bram_addr), bus.bram_wr_data, cyc});
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic t, input logic s);
    bus.din_valid = v;
    bus.din       = d;
    trig          = t;
    ctrl_stop     = s;
    log_q.push_back('{ctrl_arm, ctrl_trig_en, t, s, v, d, cyc});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Expected writes from the log: find the arm edge, then the first qualifying
  // word (unless stopped first), then take valid words until full or stopped.
  task automatic predict();
    int   r  = -1;
    int   st = -1;
    logic p  = arm_prev;
    exp_q.delete();
    m_busy = last_busy;
    m_done = last_done;
    m_cnt  = last_cnt;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].arm && !p) begin
        r = i;
        break;
      end
      p = log_q[i].arm;
    end
    if (r >= 0) begin
      m_busy = 1;
      m_done = 0;
      for (int j = r + 1; j < log_q.size(); j++) begin
        if (log_q[j].stop) begin
          m_busy = 0;
          break;
        end
        if (log_q[j].valid && (log_q[j].trig || !log_q[j].ten)) begin
          st = j;
          break;
        end
      end
      if (st >= 0) begin
        for (int j = st; j < log_q.size(); j++) begin
          if (log_q[j].valid) exp_q.push_back('{exp_q.size(), log_q[j].din, log_q[j].cyc + 1});
          if (exp_q.size() == DEPTH || log_q[j].stop) begin
            m_busy = 0;
            m_done = 1;
            break;
          end
        end
      end
      m_cnt = exp_q.size();
    end
    if (log_q.size() > 0) arm_prev = log_q[log_q.size()-1].arm;
  endtask

  task automatic compare_run(input string name);
    int e0 = errors;
    predict();
    check({name, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (errors - e0 > 8) break;
      check({name, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({name, "_data"}, obs_q[i].data, exp_q[i].data);
      check({name, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
    end
    check({name, "_busy"},  {63'd0, status_busy}, {63'd0, m_busy});
    check({name, "_done"},  {63'd0, status_done}, {63'd0, m_done});
    check({name, "_count"}, status_count, m_cnt);
    last_busy = m_busy;
    last_done = m_done;
    last_cnt  = m_cnt;
    obs_q.delete();
    log_q.delete();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    trig          = 1'b0;
    ctrl_stop     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ctl",  {50'd0, bus.bram_we, bus.bram_en_a, status_busy, status_done, status_count}, 64'd0);
    check("rst_addr", bus.bram_addr, 64'd0);
    check("rst_data", bus.bram_wr_data, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    arm_prev  = ctrl_arm;
    last_busy = 0;
    last_done = 0;
    last_cnt  = 0;
    obs_q.delete();
    log_q.delete();
  endtask

  // vmod: 1 = every cycle valid, N = 1-on/(N-1)-off, 0 = random valid
  task automatic run_capture(input string name, input logic ten, input int vmod,
                             input int trig_after, input int stop_at, input bit seq,
                             input int post);
    int            vc  = 0;
    int            n   = 0;
    int            k   = 0;
    bit            fin = 0;
    logic          v, t, s;
    logic [DW-1:0] d;
    ctrl_trig_en = ten;
    ctrl_arm     = 1'b1;
    step(1'b1, 64'hDEAD_0000_0000_BEEF, 1'b0, 1'b0);
    ctrl_arm = 1'b0;
    check({name, "_armed"}, {62'd0, status_busy, status_done}, 64'd2);
    while (!fin && n < 5000) begin
      v = (vmod <= 0) ? ($urandom_range(0, 1) == 1) : ((n % vmod) == 0);
      n++;
      t = 1'b0;
      s = 1'b0;
      d = {$urandom, $urandom};
      if (v) begin
        vc++;
        if (vc > trig_after) begin
          k = vc - trig_after;
          if (k == 1) begin
            t = 1'b1;
            if (ten) d = 64'hABCD;
          end else begin
            t = ($urandom_range(0, 3) == 0);
          end
          if (seq) d = 64'(k - 1);
          if (stop_at > 0 && k == stop_at) s = 1'b1;
          if (k == DEPTH || s) fin = 1;
        end
      end else begin
        t = ($urandom_range(0, 3) == 0);
      end
      step(v, d, t, s);
    end
    repeat (post) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    idle(2);
    if (ten) begin
      if (obs_q.size() > 0) check({name, "_first"}, obs_q[0].data, 64'hABCD);
      else check({name, "_first_missing"}, obs_q.size(), 64'd1);
    end
    compare_run(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;
    do_reset();

    run_capture("full", 1'b0, 1, 0, 0, 1'b1, 5);
    run_capture("trig", 1'b1, 1, 50, 0, 1'b0, 0);
    run_capture("gap",  1'b0, 3, 0, 0, 1'b0, 0);
    run_capture("stop", 1'b0, 1, 0, 100, 1'b0, 20);

    // stop while armed: nothing written, back to idle
    ctrl_trig_en = 1'b1;
    ctrl_arm     = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    ctrl_arm = 1'b0;
    repeat (5) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (5) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
    idle(2);
    compare_run("armstop");

    // arm level held through reset
    ctrl_trig_en = 1'b0;
    ctrl_arm     = 1'b1;
    do_reset();
    repeat (8) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    check("hold_noarm", {63'd0, status_busy}, 64'd0);
    ctrl_arm = 1'b0;
    idle(1);
    ctrl_arm = 1'b1;
    idle(1);
    check("hold_rearm", {63'd0, status_busy}, 64'd1);
    repeat (20) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    ctrl_arm = 1'b0;
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    ctrl_arm = 1'b1;
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (10) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    ctrl_arm = 1'b0;
    idle(3);
    compare_run("hold");

    // reset in the middle of a capture
    ctrl_arm = 1'b1;
    idle(1);
    ctrl_arm = 1'b0;
    repeat (500) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    compare_run("prerst");
    do_reset();
    run_capture("postrst", 1'b0, 0, 0, 40, 1'b0, 5);

    for (int it = 0; it < 4; it++) begin
      logic ten;
      ten = $urandom_range(0, 1);
      run_capture("rnd", ten, $urandom_range(0, 3), ten ? $urandom_range(0, 20) : 0,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, 900) : 0, 1'b0, 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/testing3_pfb_snap_ctrl.md
Name: testing3_pfb_snap_ctrl

Overview:
Fabric-side capture controller that fills the PFB output snapshot BRAM through its 64-bit port A.
- Software arms it through register bits, and it optionally waits for a trigger.
- It then writes a contiguous block of valid PFB output words from address 0 upward and raises done.
- The CPU reads the buffer back through the BRAM's 32-bit port B.
- This block drives the BRAM's bram_we, bram_en_a, bram_addr and bram_wr_data inputs directly.

Parameters:
DATA_WIDTH, 64, width of a captured word; equals BRAM port A data width
ADDR_WIDTH, 10, BRAM port A address width; buffer depth is 2^ADDR_WIDTH words

Ports:
clk  in  1  fabric clock, shared with BRAM port A
rst  in  1  synchronous active-high reset
ctrl_arm  in  1  software arm level; only a rising edge acts
ctrl_trig_en  in  1  1 = wait for trig after arm; 0 = start on first valid word after arm
ctrl_stop  in  1  software early-stop request, level
trig  in  1  capture trigger, sampled only while ARMED
din  in  DATA_WIDTH  PFB output word
din_valid  in  1  din qualifier
bram_we  out  1  BRAM port A write enable
bram_en_a  out  1  BRAM port A enable
bram_addr  out  ADDR_WIDTH  BRAM port A address
bram_wr_data  out  DATA_WIDTH  BRAM port A write data
status_busy  out  1  high in ARMED or CAPTURE
status_done  out  1  high in DONE
status_count  out  ADDR_WIDTH+1  number of words written in the current or last capture

Behaviour:
- Reset (synchronous, active high):
  - state IDLE.
  - All outputs 0.
  - The arm edge-detect register loads the current ctrl_arm value, so a level already high at reset does not arm.
  - Reset mid-capture aborts; BRAM contents are left as-is.
- Arm edge: arm_rise = ctrl_arm & ~arm_q, with arm_q registered every cycle.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: arm_rise -> ARMED, count cleared to 0.
  - DONE: arm_rise -> ARMED, count cleared to 0, status_done drops on the same clock.
  - ARMED: the start condition is din_valid & (trig | ~ctrl_trig_en).
    - On start, write din to address 0, count <= 1, go to CAPTURE.
    - trig without din_valid does not start; the trigger is not latched.
    - ctrl_stop in ARMED -> IDLE, nothing written.
  - CAPTURE: each din_valid writes din to address count[ADDR_WIDTH-1:0] and increments count.
    - When the write to address 2^ADDR_WIDTH-1 occurs (count becomes 2^ADDR_WIDTH), go to DONE.
    - ctrl_stop in CAPTURE -> DONE. If din_valid is high the same cycle, that word is written and counted first.
    - arm_rise in ARMED or CAPTURE is ignored.
- Port A timing: registered, 1-cycle latency.
  - A qualifying input sample at edge N produces bram_we=1, bram_en_a=1, the address and the data during the cycle after edge N.
  - In all other cycles bram_we=0 and bram_en_a=0.
  - bram_addr and bram_wr_data hold their last values when not writing.
- Address never wraps. At most 2^ADDR_WIDTH writes per capture, and no write ever occurs outside CAPTURE or the ARMED start cycle.
- status_count saturates at 2^ADDR_WIDTH. It holds its value in DONE and IDLE until the next arm.
- status_busy and status_done are registered from state; they are never both high.
- din_valid gaps in CAPTURE pause the address; there is no timeout.

Test Plan:
1. Reset, then pulse ctrl_arm with ctrl_trig_en=0 and din_valid=1 continuously, din = 0,1,2...
   -> 1024 writes at addresses 0..1023 with data 0..1023, bram_we high for 1024 consecutive cycles.
   -> status_done=1, status_count=1024.
2. Set ctrl_trig_en=1, arm, drive 50 valid words with trig=0, then trig=1 on din=0xABCD.
   -> first write is 0xABCD at address 0; nothing is written before it.
3. Apply din_valid with a 1-on/2-off pattern during capture.
   -> addresses stay contiguous; capture completes after 1024 valid words, about 3072 cycles.
4. Assert ctrl_stop on the cycle carrying the 100th valid word.
   -> the word is written at address 99, state DONE, status_count=100.
   -> no further writes even though din_valid continues.
5. Hold ctrl_arm high through reset deassertion.
   -> no arm occurs. Drop ctrl_arm and raise it again -> ARMED.
   -> a second rising edge while in CAPTURE has no effect.
6. Assert rst at count=500.
   -> the next cycle has all outputs 0 and state IDLE; a new arm restarts at address 0.
